priority_dec_2_4_v: RTL and testbench

PRIORITY_DEC_2_4_V -- requirements
Module: priority_dec_2_4_v

---
 rtl/priority_dec_2_4_v.sv | 103 ++++++++++
 tb/tb_priority_dec_2_4_v.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/priority_dec_2_4_v.sv
// 2-to-4 line decoder that holds each decoded line for HOLD_CYCLES cycles.
// Behind the active line sits a one-entry pending slot, and it has a sticky overrun flag.
module priority_dec_2_4_v #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [3:0] o_line,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] line_q, line_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_full_q, pend_full_d;
  logic [1:0] pend_code_q, pend_code_d;
  logic       overrun_q;
  logic       accept;

  function automatic logic [3:0] decode(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // Handshake: a code transfers on a rising edge with i_valid=1 and o_ready=1;
  // o_ready comes only from the pending register, so it never depends on i_valid.
  assign accept = i_valid && !pend_full_q;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
          line_d  = decode(i_code);
          cnt_d   = RELOAD;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (accept) begin
            pend_full_d = 1'b1;
            pend_code_d = i_code;
          end
        end else if (pend_full_q) begin
          line_d      = decode(pend_code_q);
          cnt_d       = RELOAD;
          pend_full_d = 1'b0;
        end else if (accept) begin
          // Final hold cycle with nothing queued: hand over directly, no gap.
          line_d = decode(i_code);
          cnt_d  = RELOAD;
        end else begin
          state_d = IDLE;
          line_d  = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 4'b0000;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      line_q      <= 4'b0000;
      cnt_q       <= 8'd0;
      pend_full_q <= 1'b0;
      pend_code_q <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
      if (i_valid && pend_full_q) overrun_q <= 1'b1;
    end
  end

  assign o_ready   = !pend_full_q;
  assign o_line    = line_q;
  assign o_busy    = (state_q == HOLD);
  assign o_done    = (state_q == HOLD) && (cnt_q == 8'd0);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_priority_dec_2_4_v.sv
// Bench for priority_dec_2_4_v: vector table on a HOLD_CYCLES=4 instance,
// hand sequences for reset mid-hold and 1-cycle streaming on a HOLD_CYCLES=1 instance.
module tb_priority_dec_2_4_v;

  typedef struct {
    logic       valid;
    logic [1:0] code;
    logic [3:0] line;
    logic       busy;
    logic       done;
    logic       ready;
    logic       ovr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] code4 = 2'b00, code1 = 2'b00;
  logic       valid4 = 1'b0, valid1 = 1'b0;
  logic       ready4, busy4, done4, ovr4;
  logic       ready1, busy1, done1, ovr1;
  logic [3:0] line4, line1;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  priority_dec_2_4_v #(.HOLD_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(code4), .i_valid(valid4),
    .o_ready(ready4), .o_line(line4), .o_busy(busy4), .o_done(done4), .o_overrun(ovr4)
  );

  priority_dec_2_4_v #(.HOLD_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_code(code1), .i_valid(valid1),
    .o_ready(ready1), .o_line(line1), .o_busy(busy1), .o_done(done1), .o_overrun(ovr1)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] c, input logic [3:0] l,
                     input logic b, input logic d, input logic r, input logic o);
    vec_t e;
    e.valid = v; e.code = c; e.line = l; e.busy = b; e.done = d; e.ready = r; e.ovr = o;
    vq.push_back(e);
  endtask

  // Drive inputs for the next edge, then sample in the following low phase.
  task automatic step4(input logic v, input logic [1:0] c);
    valid4 = v;
    code4  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step1(input logic v, input logic [1:0] c);
    valid1 = v;
    code1  = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Single code 10, then idle with garbage code and valid low
    add(1, 2'd2, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 1, 1, 0);
    add(0, 2'd3, 4'b0000, 0, 0, 1, 0);
    // Back-to-back 01 then 11
    add(1, 2'd1, 4'b0010, 1, 0, 1, 0);
    add(1, 2'd3, 4'b0010, 1, 0, 0, 0);
    add(0, 2'd0, 4'b0010, 1, 0, 0, 0);
    add(0, 2'd0, 4'b0010, 1, 1, 0, 0);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 0);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 0);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 0);
    add(0, 2'd0, 4'b1000, 1, 1, 1, 0);
    add(0, 2'd0, 4'b0000, 0, 0, 1, 0);
    // Bypass: 00, then 10 offered only on the done cycle
    add(1, 2'd0, 4'b0001, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0001, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0001, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0001, 1, 1, 1, 0);
    add(1, 2'd2, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 0, 1, 0);
    add(0, 2'd0, 4'b0100, 1, 1, 1, 0);
    add(0, 2'd0, 4'b0000, 0, 0, 1, 0);
    // Overrun: 01, 11 fills pending, 00 is dropped
    add(1, 2'd1, 4'b0010, 1, 0, 1, 0);
    add(1, 2'd3, 4'b0010, 1, 0, 0, 0);
    add(1, 2'd0, 4'b0010, 1, 0, 0, 1);
    add(0, 2'd0, 4'b0010, 1, 1, 0, 1);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 1);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 1);
    add(0, 2'd0, 4'b1000, 1, 0, 1, 1);
    add(0, 2'd0, 4'b1000, 1, 1, 1, 1);
    add(0, 2'd0, 4'b0000, 0, 0, 1, 1);
    add(0, 2'd0, 4'b0000, 0, 0, 1, 1);

    // Reset state, checked before any clock edge
    #1;
    chk("rst_line", line4, 4'b0000);
    chk("rst_busy", {3'b0, busy4}, 4'd0);
    chk("rst_done", {3'b0, done4}, 4'd0);
    chk("rst_ready", {3'b0, ready4}, 4'd1);
    chk("rst_ovr", {3'b0, ovr4}, 4'd0);
    chk("rst_ready1", {3'b0, ready1}, 4'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step4(vq[i].valid, vq[i].code);
      chk($sformatf("v%0d_line", i), line4, vq[i].line);
      chk($sformatf("v%0d_busy", i), {3'b0, busy4}, {3'b0, vq[i].busy});
      chk($sformatf("v%0d_done", i), {3'b0, done4}, {3'b0, vq[i].done});
      chk($sformatf("v%0d_ready", i), {3'b0, ready4}, {3'b0, vq[i].ready});
      chk($sformatf("v%0d_ovr", i), {3'b0, ovr4}, {3'b0, vq[i].ovr});
    end

    // Reset mid-hold with pending full: everything clears without a clock edge
    step4(1, 2'd3);
    step4(1, 2'd1);
    chk("pre_rst_line", line4, 4'b1000);
    chk("pre_rst_ready", {3'b0, ready4}, 4'd0);
    valid4 = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_line", line4, 4'b0000);
    chk("async_busy", {3'b0, busy4}, 4'd0);
    chk("async_done", {3'b0, done4}, 4'd0);
    chk("async_ready", {3'b0, ready4}, 4'd1);
    chk("async_ovr", {3'b0, ovr4}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step4(0, 2'd0);
    chk("post_rst_idle", line4, 4'b0000);
    step4(1, 2'd0);
    chk("post_rst_line0", line4, 4'b0001);
    for (int k = 1; k < 4; k++) begin
      step4(0, 2'd0);
      chk($sformatf("post_rst_line%0d", k), line4, 4'b0001);
    end
    chk("post_rst_done", {3'b0, done4}, 4'd1);
    step4(0, 2'd0);
    chk("post_rst_no_pend", line4, 4'b0000);

    // HOLD_CYCLES=1 streaming: one line per cycle, ready never drops
    for (int k = 0; k < 4; k++) begin
      step1(1, 2'(k));
      chk($sformatf("s%0d_line", k), line1, 4'(1 << k));
      chk($sformatf("s%0d_done", k), {3'b0, done1}, 4'd1);
      chk($sformatf("s%0d_ready", k), {3'b0, ready1}, 4'd1);
    end
    step1(0, 2'd0);
    chk("s_idle_line", line1, 4'b0000);
    chk("s_idle_done", {3'b0, done1}, 4'd0);
    chk("s_ovr", {3'b0, ovr1}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
